// File: rtl/seg7_scan_arb.sv
// Two-requester, 4-digit multiplexed 7-segment driver. A round-robin arbiter admits
// one BCD word per frame, and the word is loaded only at the frame boundary.
module seg7_scan_arb #(
    parameter int SCAN_WAIT = 27_000,
    parameter int BLANK     = 270,
    parameter bit LZB       = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    input  logic [15:0] i_a_bcd,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [15:0] i_b_bcd,
    output logic        o_b_ready,
    output logic        o_owner,
    output logic        o_frame,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_dig
);
    localparam int              CW       = $clog2(SCAN_WAIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_WAIT - 1);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } scan_phase_t;

    // Handshake: a word moves when valid and ready are both high in the same cycle.
    // Ready is raised only in the frame's last cycle, for at most one side.

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   buf_q, buf_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    scan_phase_t   phase_d;
    logic          lz_d;
    logic [3:0]    nib_d;
    logic          frame_w;
    logic          grant_a;
    logic          grant_b;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h02;
        endcase
    endfunction

    // rr_q: 0 = A has priority on a tie, 1 = B.
    assign frame_w = (idx_q == 2'd3) && (cnt_q == CNT_LAST);
    assign grant_a = frame_w && !i_rst && i_a_valid && (!i_b_valid || !rr_q);
    assign grant_b = frame_w && !i_rst && i_b_valid && (!i_a_valid || rr_q);

    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        idx_d   = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
        buf_d   = buf_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (grant_a) begin
            buf_d   = i_a_bcd;
            owner_d = 1'b0;
            rr_d    = 1'b1;
        end else if (grant_b) begin
            buf_d   = i_b_bcd;
            owner_d = 1'b1;
            rr_d    = 1'b0;
        end

        // Outputs are built from next state so they line up with the cycle they appear in.
        phase_d = (int'(cnt_d) < BLANK) ? PH_BLANK : PH_DRIVE;
        case (idx_d)
            2'd1:    lz_d = LZB && (buf_d[15:4] == 12'h000);
            2'd2:    lz_d = LZB && (buf_d[15:8] == 8'h00);
            2'd3:    lz_d = LZB && (buf_d[15:12] == 4'h0);
            default: lz_d = 1'b0;
        endcase
        nib_d = buf_d[{idx_d, 2'b00} +: 4];
        seg_d = 8'h00;
        dig_d = 4'b1111;
        if (phase_d == PH_DRIVE && !lz_d) begin
            dig_d = ~(4'b0001 << idx_d);
            seg_d = seg_decode(nib_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            buf_q   <= 16'h0000;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            seg_q   <= 8'h00;
            dig_q   <= 4'b1111;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign o_a_ready = grant_a;
    assign o_b_ready = grant_b;
    assign o_owner   = owner_q;
    assign o_frame   = frame_w;
    assign o_seg     = seg_q;
    assign o_dig     = dig_q;
endmodule

// File: tb/tb_seg7_scan_arb.sv
// Bench for seg7_scan_arb: cycle-count reference model checked every cycle on two
// instances (BLANK=2 and BLANK=0), literal checks of the listed scenarios, random traffic.
module tb_seg7_scan_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [15:0] a_bcd = 16'h0;
    logic        b_valid = 1'b0;
    logic [15:0] b_bcd = 16'h0;
    logic        a_ready, b_ready, owner, frame;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        z_a_ready, z_b_ready, z_owner, z_frame;
    logic [7:0]  z_seg;
    logic [3:0]  z_dig;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seg7_scan_arb #(.SCAN_WAIT(8), .BLANK(2), .LZB(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_bcd(a_bcd), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_bcd(b_bcd), .o_b_ready(b_ready),
        .o_owner(owner), .o_frame(frame), .o_seg(seg), .o_dig(dig)
    );

    seg7_scan_arb #(.SCAN_WAIT(8), .BLANK(0), .LZB(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_bcd(a_bcd), .o_a_ready(z_a_ready),
        .i_b_valid(b_valid), .i_b_bcd(b_bcd), .o_b_ready(z_b_ready),
        .o_owner(z_owner), .o_frame(z_frame), .o_seg(z_seg), .o_dig(z_dig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] dec [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};

    // Returns {seg, dig} for word w at cycle c (since reset release) with the given dead time.
    function automatic logic [11:0] expect_disp(input logic [15:0] w, input int c, input int blank);
        int         slot;
        int         pos;
        logic [3:0] nib;
        logic [3:0] d;
        slot = (c / 8) % 4;
        pos  = c % 8;
        nib  = w[4*slot +: 4];
        d    = ~(4'b0001 << slot);
        if (c == 0 || pos < blank || (slot > 0 && (w >> (4 * slot)) == 16'h0))
            return {8'h00, 4'hF};
        return {dec[nib], d};
    endfunction

    int          m_cyc = 0;
    logic [15:0] m_buf = 16'h0;
    logic        m_owner = 1'b0;
    logic        m_rr = 1'b0;
    bit          m_live = 1'b0;
    logic        frame_e, ga, gb;
    logic [11:0] disp, disp0;

    always @(negedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_cyc   = 0;
            m_buf   = 16'h0;
            m_owner = 1'b0;
            m_rr    = 1'b0;
        end else if (m_live) begin
            frame_e = (m_cyc % 32) == 31;
            ga = frame_e && a_valid && (!b_valid || m_rr == 1'b0);
            gb = frame_e && b_valid && (!a_valid || m_rr == 1'b1);
            disp  = expect_disp(m_buf, m_cyc, 2);
            disp0 = expect_disp(m_buf, m_cyc, 0);
            chk("m_frame", 32'(frame), 32'(frame_e));
            chk("m_a_ready", 32'(a_ready), 32'(ga));
            chk("m_b_ready", 32'(b_ready), 32'(gb));
            chk("m_owner", 32'(owner), 32'(m_owner));
            chk("m_seg", 32'(seg), 32'(disp[11:4]));
            chk("m_dig", 32'(dig), 32'(disp[3:0]));
            chk("m0_seg", 32'(z_seg), 32'(disp0[11:4]));
            chk("m0_dig", 32'(z_dig), 32'(disp0[3:0]));
            chk("m0_owner", 32'(z_owner), 32'(m_owner));
            chk("m0_ready", 32'({z_a_ready, z_b_ready}), 32'({ga, gb}));
            if (ga) begin
                m_buf = a_bcd; m_owner = 1'b0; m_rr = 1'b1;
            end else if (gb) begin
                m_buf = b_bcd; m_owner = 1'b1; m_rr = 1'b0;
            end
            m_cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic at(input int k);
        while (cyc < k) step();
        #2;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++)
            w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return w;
    endfunction

    logic [3:0] dtab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic       sa, sb;

    initial begin
        step();

        // Reset, no requests
        do_reset();
        at(0);  chk("rst_seg", 32'(seg), 32'h00); chk("rst_dig", 32'(dig), 32'hF);
        chk("rst_rdy", 32'({a_ready, b_ready}), 32'h0); chk("rst_frame", 32'(frame), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        at(1);  chk("t1_dig1", 32'(dig), 32'hF);
        at(2);  chk("t1_seg2", 32'(seg), 32'hFC); chk("t1_dig2", 32'(dig), 32'hE);
        at(7);  chk("t1_dig7", 32'(dig), 32'hE);
        at(8);  chk("t1_dig8", 32'(dig), 32'hF);
        at(30); chk("t1_frame30", 32'(frame), 32'h0);
        at(31); chk("t1_frame31", 32'(frame), 32'h1);

        // A offers 1234
        do_reset();
        a_bcd = 16'h1234; a_valid = 1'b1;
        at(30); chk("t2_rdy30", 32'(a_ready), 32'h0);
        at(31); chk("t2_rdy31", 32'(a_ready), 32'h1);
        step(); a_valid = 1'b0;
        at(35); chk("t2_seg35", 32'(seg), 32'h66); chk("t2_dig35", 32'(dig), 32'hE);
        at(60); chk("t2_seg60", 32'(seg), 32'h60); chk("t2_dig60", 32'(dig), 32'h7);
        chk("t2_owner", 32'(owner), 32'h0);

        // A and B both held valid
        do_reset();
        a_bcd = 16'h0001; b_bcd = 16'h0002; a_valid = 1'b1; b_valid = 1'b1;
        at(31); chk("t3_rdy31", 32'({a_ready, b_ready}), 32'h2);
        at(63); chk("t3_rdy63", 32'({a_ready, b_ready}), 32'h1);
        at(66); chk("t3_seg66", 32'(seg), 32'hDA); chk("t3_owner66", 32'(owner), 32'h1);
        at(95); chk("t3_rdy95", 32'({a_ready, b_ready}), 32'h2);
        step(); a_valid = 1'b0; b_valid = 1'b0;

        // Dash and leading-zero blanking
        do_reset();
        a_bcd = 16'h0A50; a_valid = 1'b1;
        at(31); step(); a_valid = 1'b0;
        at(35); chk("t4_d0", 32'(seg), 32'hFC);
        at(43); chk("t4_d1", 32'(seg), 32'hB6);
        at(51); chk("t4_d2", 32'(seg), 32'h02); chk("t4_dig2", 32'(dig), 32'hB);
        at(59); chk("t4_d3seg", 32'(seg), 32'h00); chk("t4_d3dig", 32'(dig), 32'hF);
        at(62); chk("t4_d3dig62", 32'(dig), 32'hF);

        // Reset mid-frame while B owns the display
        do_reset();
        b_bcd = 16'h0002; b_valid = 1'b1;
        at(31); chk("t5_brdy", 32'(b_ready), 32'h1);
        step(); b_valid = 1'b0;
        at(40); chk("t5_owner40", 32'(owner), 32'h1);
        while (cyc < 50) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        at(51); chk("t5_dig", 32'(dig), 32'hF); chk("t5_seg", 32'(seg), 32'h00);
        chk("t5_owner", 32'(owner), 32'h0);
        at(53); chk("t5_seg53", 32'(seg), 32'hFC); chk("t5_dig53", 32'(dig), 32'hE);
        at(82); chk("t5_frame", 32'(frame), 32'h1);

        // No dead time (second instance)
        do_reset();
        a_bcd = 16'h8888; a_valid = 1'b1;
        at(31); step(); a_valid = 1'b0;
        for (int k = 32; k < 64; k++) begin
            at(k);
            chk("t6_seg", 32'(z_seg), 32'hFE);
            chk("t6_dig", 32'(z_dig), 32'(dtab[(k - 32) / 8]));
        end

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            #2;
            sa = a_ready;
            sb = b_ready;
            step();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
            end else begin
                if (a_valid && (sa || $urandom_range(0, 199) == 0)) a_valid = 1'b0;
                else if (!a_valid && $urandom_range(0, 15) == 0) begin
                    a_valid = 1'b1; a_bcd = rand_word();
                end
                if (b_valid && (sb || $urandom_range(0, 199) == 0)) b_valid = 1'b0;
                else if (!b_valid && $urandom_range(0, 15) == 0) begin
                    b_valid = 1'b1; b_bcd = rand_word();
                end
            end
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
